// File: rtl/fpu_divsqrt_pkg.sv
// -----------------------------------------------------------------------------
// fpu_divsqrt_pkg
// Shared definitions for the iterative significand divide / square-root unit:
//   - state_e     : control FSM encoding (IDLE, BUSY, FIN, DONE)
//   - SP_SIG_W    : single-precision significand width (hidden bit included)
//   - DP_SIG_W    : double-precision significand width (hidden bit included)
//   - calc_qw     : number of quotient/root bits produced for a given SIG_W
//   - calc_res_w  : result width {quotient, sticky} for a given SIG_W
// -----------------------------------------------------------------------------
package fpu_divsqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int SP_SIG_W = 24;
  localparam int DP_SIG_W = 53;

  // One integer bit, SIG_W-1 fraction bits, then guard and round.
  function automatic int calc_qw(input int sig_w);
    return sig_w + 2;
  endfunction

  // Quotient bits plus the trailing sticky bit.
  function automatic int calc_res_w(input int sig_w);
    return calc_qw(sig_w) + 1;
  endfunction

  localparam int SP_QW    = calc_qw(SP_SIG_W);
  localparam int SP_RES_W = calc_res_w(SP_SIG_W);
  localparam int DP_QW    = calc_qw(DP_SIG_W);
  localparam int DP_RES_W = calc_res_w(DP_SIG_W);

endpackage

// File: rtl/divsqrt_step.sv
// -----------------------------------------------------------------------------
// divsqrt_step
// Combinational single iteration of the restoring divide / square-root
// recurrence.
// Ports:
//   i_rem       : current partial remainder (2*QW+2 bits; divide uses the low
//                 SIG_W+2 bits, sqrt uses the whole in-place radicand)
//   i_divisor   : divisor significand (divide mode)
//   i_root      : root bits decided so far, right aligned (sqrt mode)
//   i_cnt       : iteration index, 0 for the most significant result bit
//   i_sqrt_mode : 0 = divide, 1 = square root
//   o_rem       : next partial remainder
//   o_q_bit     : result bit produced by this iteration
// -----------------------------------------------------------------------------
module divsqrt_step
  import fpu_divsqrt_pkg::*;
#(
  parameter int SIG_W = SP_SIG_W,
  parameter int QW    = calc_qw(SIG_W),
  parameter int CNT_W = $clog2(QW + 1)
) (
  input  logic [2*QW+1:0]  i_rem,
  input  logic [SIG_W-1:0] i_divisor,
  input  logic [QW-1:0]    i_root,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_sqrt_mode,
  output logic [2*QW+1:0]  o_rem,
  output logic             o_q_bit
);

  localparam int REM_W = 2*QW + 2;
  localparam int DR_W  = SIG_W + 2;

  // ---------------- divide: trial = rem - b, keep on non-negative, then <<1
  logic [DR_W:0]   w_div_trial;
  logic            w_div_q;
  logic [DR_W-1:0] w_div_keep;
  logic [REM_W-1:0] w_div_rem;

  assign w_div_trial = {1'b0, i_rem[DR_W-1:0]} - {{(DR_W+1-SIG_W){1'b0}}, i_divisor};
  assign w_div_q     = ~w_div_trial[DR_W];
  assign w_div_keep  = w_div_q ? w_div_trial[DR_W-1:0] : i_rem[DR_W-1:0];
  // The kept remainder is below the divisor, so the shift never overflows.
  assign w_div_rem   = {{(REM_W-DR_W-1){1'b0}}, w_div_keep, 1'b0};

  // ---------------- sqrt: remainder stays in place inside the radicand;
  // subtract {root,01} aligned to the bit pair for this iteration, i.e.
  // shifted left by 2*(QW-1-cnt).
  logic [CNT_W-1:0] w_pos;
  logic [CNT_W:0]   w_shamt;
  logic [REM_W:0]   w_sub_base;
  logic [REM_W:0]   w_sub;
  logic [REM_W:0]   w_sq_trial;
  logic             w_sq_q;
  logic [REM_W-1:0] w_sq_rem;

  assign w_pos      = CNT_W'(QW - 1) - i_cnt;
  assign w_shamt    = {w_pos, 1'b0};
  assign w_sub_base = {{(REM_W-1-QW){1'b0}}, i_root, 2'b01};
  assign w_sub      = w_sub_base << w_shamt;
  assign w_sq_trial = {1'b0, i_rem} - w_sub;
  assign w_sq_q     = ~w_sq_trial[REM_W];
  assign w_sq_rem   = w_sq_q ? w_sq_trial[REM_W-1:0] : i_rem;

  assign o_rem   = i_sqrt_mode ? w_sq_rem : w_div_rem;
  assign o_q_bit = i_sqrt_mode ? w_sq_q   : w_div_q;

endmodule

// File: rtl/fpu_sig_divsqrt.sv
// -----------------------------------------------------------------------------
// fpu_sig_divsqrt
// Iterative radix-2 significand divider with a restoring square-root mode.
// One result bit per BUSY cycle, QW bits MSB first, then a sticky bit.
// Ports:
//   i_clk        : clock
//   i_rst_n      : asynchronous active-low reset
//   i_start      : start pulse, accepted only in IDLE
//   i_sqrt_mode  : 0 = a/b, 1 = sqrt(a)
//   i_exp_odd    : sqrt only, radicand is 2*a when set
//   i_a_sig      : dividend / radicand significand (msb = 1)
//   i_b_sig      : divisor significand (msb = 1, zero flags divide-by-zero)
//   i_abort      : flush any operation in flight, highest priority
//   o_busy       : iterating
//   o_out_valid  : result available
//   i_out_ready  : consumer accepts result
//   o_res_sig    : {q[QW-1:0], sticky}, bit QW is the integer bit
//   o_div_zero   : divisor was zero in divide mode
// -----------------------------------------------------------------------------
module fpu_sig_divsqrt
  import fpu_divsqrt_pkg::*;
#(
  parameter int SIG_W = SP_SIG_W,
  parameter int QW    = calc_qw(SIG_W),
  parameter int CNT_W = $clog2(QW + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sqrt_mode,
  input  logic             i_exp_odd,
  input  logic [SIG_W-1:0] i_a_sig,
  input  logic [SIG_W-1:0] i_b_sig,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [QW:0]      o_res_sig,
  output logic             o_div_zero
);

  localparam int RES_W  = QW + 1;
  localparam int REM_W  = 2*QW + 2;
  // Aligns a (SIG_W-1 fraction bits) so the radicand carries 2*(QW-1)
  // fraction bits; the integer root then has QW-1 fraction bits.
  localparam int RAD_SH = 2*QW - SIG_W - 1;

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [REM_W-1:0] r_rem;
  logic [QW-1:0]    r_q;
  logic [SIG_W-1:0] r_b;
  logic             r_sqrt;
  logic             r_dz_pend;
  logic [RES_W-1:0] r_res;
  logic             r_div_zero;

  logic             w_div_by_zero;
  logic [REM_W-1:0] w_a_ext;
  logic [REM_W-1:0] w_rem_init;
  logic [REM_W-1:0] w_step_rem;
  logic             w_step_q;

  assign w_div_by_zero = ~i_sqrt_mode & ~(|i_b_sig);
  assign w_a_ext       = {{(REM_W-SIG_W){1'b0}}, i_a_sig};
  assign w_rem_init    = !i_sqrt_mode ? w_a_ext :
                         i_exp_odd    ? (w_a_ext << (RAD_SH + 1)) :
                                        (w_a_ext << RAD_SH);

  divsqrt_step #(
    .SIG_W (SIG_W),
    .QW    (QW),
    .CNT_W (CNT_W)
  ) u_step (
    .i_rem       (r_rem),
    .i_divisor   (r_b),
    .i_root      (r_q),
    .i_cnt       (r_cnt),
    .i_sqrt_mode (r_sqrt),
    .o_rem       (w_step_rem),
    .o_q_bit     (w_step_q)
  );

  // ---------------- FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // ---------------- FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_state_next = w_div_by_zero ? ST_FIN : ST_BUSY;
        // The last iteration is the one that takes the counter to QW.
        ST_BUSY: if (r_cnt == CNT_W'(QW - 1)) w_state_next = ST_FIN;
        ST_FIN:  w_state_next = ST_DONE;
        ST_DONE: if (i_out_ready) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs
  always_comb begin
    o_busy      = (r_state == ST_BUSY);
    o_out_valid = (r_state == ST_DONE);
  end

  assign o_res_sig  = r_res;
  assign o_div_zero = r_div_zero;

  // ---------------- datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_b        <= '0;
      r_sqrt     <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_res      <= '0;
      r_div_zero <= 1'b0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_rem     <= w_rem_init;
            r_b       <= i_b_sig;
            r_sqrt    <= i_sqrt_mode;
            r_dz_pend <= w_div_by_zero;
          end
        end
        ST_BUSY: begin
          if (r_cnt != CNT_W'(QW)) begin
            r_rem <= w_step_rem;
            r_q   <= {r_q[QW-2:0], w_step_q};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIN: begin
          r_res      <= r_dz_pend ? {RES_W{1'b1}} : {r_q, |r_rem};
          r_div_zero <= r_dz_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sig_divsqrt.sv
// -----------------------------------------------------------------------------
// tb_fpu_sig_divsqrt
// Directed bench for fpu_sig_divsqrt with SIG_W = 24, hand-computed results.
// -----------------------------------------------------------------------------
module tb_fpu_sig_divsqrt;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_sqrt_mode = 1'b0;
  logic        i_exp_odd = 1'b0;
  logic [23:0] i_a_sig = '0;
  logic [23:0] i_b_sig = '0;
  logic        i_abort = 1'b0;
  logic        o_busy;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [26:0] o_res_sig;
  logic        o_div_zero;

  int checks = 0;
  int errors = 0;

  fpu_sig_divsqrt #(.SIG_W(24)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_sqrt_mode (i_sqrt_mode),
    .i_exp_odd   (i_exp_odd),
    .i_a_sig     (i_a_sig),
    .i_b_sig     (i_b_sig),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_res_sig   (o_res_sig),
    .o_div_zero  (o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle (cycle 0); returns #1 after the accepting edge.
  task automatic start_op(input logic sq, input logic odd, input logic [23:0] a,
                          input logic [23:0] b);
    @(negedge i_clk);
    i_sqrt_mode = sq;
    i_exp_odd   = odd;
    i_a_sig     = a;
    i_b_sig     = b;
    i_start     = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Cycle index c0 is the current cycle; returns the cycle out_valid is seen.
  task automatic wait_valid(input int c0, output int cyc);
    cyc = c0;
    while (o_out_valid !== 1'b1 && cyc < 100) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
  endtask

  // Consumer takes the result on the next edge (out_ready already high).
  task automatic finish_op(input string tag);
    @(posedge i_clk);
    #1;
    chk({tag, "_valid_drop"}, 64'(o_out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic sq, input logic odd,
                        input logic [23:0] a, input logic [23:0] b,
                        input int exp_lat, input logic [26:0] exp_res,
                        input logic exp_dz);
    int cyc;
    start_op(sq, odd, a, b);
    wait_valid(1, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_res"}, 64'(o_res_sig), 64'(exp_res));
    chk({tag, "_dz"}, 64'(o_div_zero), 64'(exp_dz));
    $display("op %s: res=%07h div_zero=%0b latency=%0d", tag, o_res_sig, o_div_zero, cyc);
    finish_op(tag);
  endtask

  initial begin
    int cyc;
    logic seen;

    // ---- reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_valid", 64'(o_out_valid), 64'd0);
    chk("rst_res", 64'(o_res_sig), 64'd0);
    chk("rst_dz", 64'(o_div_zero), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // ---- divide and sqrt vectors
    run_op("div_1_1",     1'b0, 1'b0, 24'h800000, 24'h800000, 28, 27'h4000000, 1'b0);
    run_op("div_15_1",    1'b0, 1'b0, 24'hC00000, 24'h800000, 28, 27'h6000000, 1'b0);
    run_op("div_1_15",    1'b0, 1'b0, 24'h800000, 24'hC00000, 28, 27'h2AAAAAB, 1'b0);
    run_op("sqrt_225",    1'b1, 1'b1, 24'h900000, 24'h000000, 28, 27'h6000000, 1'b0);
    run_op("sqrt_1",      1'b1, 1'b0, 24'h800000, 24'h000000, 28, 27'h4000000, 1'b0);

    // ---- backpressure, start ignored during BUSY and DONE
    i_out_ready = 1'b0;
    start_op(1'b0, 1'b0, 24'hC00000, 24'h800000);
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    chk("bp_busy_mid", 64'(o_busy), 64'd1);
    i_a_sig = 24'h800000;
    i_b_sig = 24'hC00000;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_valid(6, cyc);
    chk("bp_latency", 64'(cyc), 64'd28);
    chk("bp_res", 64'(o_res_sig), 64'(27'h6000000));
    $display("op bp_first: res=%07h latency=%0d", o_res_sig, cyc);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        i_sqrt_mode = 1'b1;
        i_a_sig     = 24'h800000;
        i_start     = 1'b1;
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      chk("bp_hold_valid", 64'(o_out_valid), 64'd1);
      chk("bp_hold_res", 64'(o_res_sig), 64'(27'h6000000));
      $display("op bp_hold[%0d]: valid=%0b res=%07h", i, o_out_valid, o_res_sig);
    end
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("bp_valid_drop", 64'(o_out_valid), 64'd0);
    chk("bp_no_restart", 64'(o_busy), 64'd0);
    @(posedge i_clk);
    #1;
    chk("bp_idle_busy", 64'(o_busy), 64'd0);

    // ---- abort at cycle 10 of BUSY
    start_op(1'b0, 1'b0, 24'h800000, 24'h800000);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    chk("abort_busy_before", 64'(o_busy), 64'd1);
    i_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_valid", 64'(o_out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    $display("op abort: busy=%0b valid_seen=%0b", o_busy, seen);

    // ---- divide by zero
    run_op("div_zero",    1'b0, 1'b0, 24'h800000, 24'h000000, 2, 27'h7FFFFFF, 1'b1);

    // ---- async reset mid-BUSY clears outputs immediately
    start_op(1'b0, 1'b0, 24'h800000, 24'h800000);
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    chk("rstmid_busy_before", 64'(o_busy), 64'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(o_busy), 64'd0);
    chk("rstmid_valid", 64'(o_out_valid), 64'd0);
    chk("rstmid_res", 64'(o_res_sig), 64'd0);
    chk("rstmid_dz", 64'(o_div_zero), 64'd0);
    $display("op reset_mid_busy: busy=%0b valid=%0b res=%07h dz=%0b",
             o_busy, o_out_valid, o_res_sig, o_div_zero);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("div_1_1_again", 1'b0, 1'b0, 24'h800000, 24'h800000, 28, 27'h4000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_sig_divsqrt.md
Name: fpu_sig_divsqrt

Overview:
- Parametrised iterative significand unit for the FPU arithmetic path: radix-2 restoring division, plus a digit-recurrence square-root mode in the same datapath.
- Next generation of the single-precision significand divider. Width is generic (single or double), sqrt is added, and a valid/ready result handshake and abort are added.
- Sits between operand pre-normalisation and the divide/sqrt post-normaliser.
- Output layout is {quotient bits, sticky}, ready for the rounding stage.

Parameters:
- SIG_W, 24, significand width including hidden bit (24 single, 53 double).
- QW, SIG_W+2, number of quotient/root bits produced: 1 integer bit, SIG_W-1 fraction bits, guard, round.
- CNT_W, $clog2(QW+1), width of the iteration counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start pulse; accepted only in IDLE.
- sqrt_mode  in  1  0 = divide a/b; 1 = square root of a.
- exp_odd  in  1  sqrt only: radicand = 2*a when set (unbiased exponent odd).
- a_sig  in  SIG_W  dividend or radicand significand; normalised, msb = 1.
- b_sig  in  SIG_W  divisor significand; normalised, msb = 1; ignored in sqrt mode.
- abort  in  1  flush any operation in flight.
- busy  out  1  high while iterating.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- res_sig  out  QW+1  {q[QW-1:0], sticky}; bit QW is the integer bit.
- div_zero  out  1  divisor was zero (b_sig == 0) in divide mode.

Behaviour:
- Reset (async, active-low) values:
  - State = IDLE.
  - busy, out_valid, div_zero = 0.
  - res_sig = 0.
  - Remainder, quotient and counter registers cleared.
- States:
  - IDLE --start--> BUSY. Operands, mode and exp_odd are captured on the start edge.
  - BUSY --counter == QW--> FIN.
  - FIN --> DONE.
  - DONE --out_valid & out_ready--> IDLE.
- start while BUSY, FIN or DONE is ignored. No queuing.
- Divide:
  - Remainder register width SIG_W+2. Initial partial remainder = a.
  - Each BUSY cycle: trial = rem - b.
    - If trial is non-negative: q bit = 1, rem = trial.
    - Otherwise: q bit = 0.
  - Then rem <<= 1. One bit per cycle, MSB first, QW cycles in total.
- Sqrt:
  - Non-restoring-free restoring recurrence on radicand (a or 2a).
  - Trial subtrahend = {root_so_far, 01} at the matching position.
  - Radicand register width 2*QW+2. Root in [1,2), so root bit QW-1 is always 1.
- FIN: sticky = |rem (final remainder non-zero). res_sig is registered. out_valid is asserted the next cycle (DONE).
- Latency: start accepted at cycle 0 -> out_valid high at cycle QW+2 (28 for SIG_W=24).
- res_sig and div_zero are held stable while out_valid = 1 and out_ready = 0.
- out_valid drops the cycle after the handshake. A new start is accepted in IDLE the following cycle.
- Divide by zero (divide mode, b_sig == 0):
  - Skip iteration: go IDLE -> FIN directly.
  - res_sig = all ones, div_zero = 1.
  - out_valid at cycle 2.
- abort, any state: return to IDLE next edge. busy = 0, out_valid = 0, counter cleared. abort has priority over start and over the handshake in the same cycle.
- Operands with msb = 0 (other than the b_sig == 0 case) give undefined results. Pre-normalisation guarantees msb = 1.
- Counter counts 0..QW and never wraps. It is cleared on entry to BUSY.

Decomposition:
- Shared package fpu_divsqrt_pkg holds:
  - the state encoding (IDLE, BUSY, FIN, DONE);
  - the SIG_W presets SP_SIG_W = 24 and DP_SIG_W = 53;
  - the derived widths QW and RES_W = QW+1.
- One natural sub-module: divsqrt_step, a combinational single-iteration trial subtract/select (rem in, operand/root in, mode -> rem out, q bit).

Test Plan (all with SIG_W = 24):
- Divide 1.0/1.0: a = b = 24'h800000 -> res_sig = 27'h4000000, div_zero = 0, out_valid at cycle 28.
- Divide 1.5/1.0: a = 24'hC00000, b = 24'h800000 -> res_sig = 27'h6000000. Divide 1.0/1.5 -> res_sig = 27'h2AAAAAB (sticky = 1).
- Sqrt: sqrt_mode = 1, exp_odd = 1, a = 24'h900000 (2.25) -> res_sig = 27'h6000000, sticky 0. sqrt(1.0), exp_odd = 0 -> 27'h4000000.
- Divide by zero: b = 0 -> div_zero = 1, res_sig = 27'h7FFFFFF, out_valid at cycle 2.
- Backpressure and ignore: hold out_ready = 0 for 5 cycles -> res_sig stable, out_valid held. A start pulsed during BUSY and during DONE is ignored.
- abort at cycle 10 of BUSY -> IDLE next cycle, no out_valid. Reset asserted mid-BUSY -> all outputs 0 immediately (async). A following 1.0/1.0 completes correctly.
